register_file_scoreboard: RTL and testbench
===========================================

Name: register_file_scoreboard

Overview:
- Architectural integer register file (x0..x31) that consumes the writeback stage's write port and serves the two decode-stage read ports.
- Write-first bypass: a read in the same cycle as a writeback to that register returns the new value.
- Per-register pending-write scoreboard: decode marks rd busy when an instruction issues; writeback retires it. Decode uses the result to stall on RAW hazards.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired to zero.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W == NUM_REGS.
- PEND_W, 2, width of each per-register pending counter; max in-flight writes per register = 2**PEND_W - 1.

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst  input  1  synchronous active-high reset
- i_rs1_addr  input  ADDR_W  read port 1 address
- i_rs2_addr  input  ADDR_W  read port 2 address
- i_rs1_used  input  1  decoded instruction reads rs1
- i_rs2_used  input  1  decoded instruction reads rs2
- o_rs1_data  output  XLEN  read port 1 data (combinational)
- o_rs2_data  output  XLEN  read port 2 data (combinational)
- i_issue_valid  input  1  decode requests issue of the current instruction
- i_issue_wr_en  input  1  issuing instruction writes rd
- i_issue_rd_addr  input  ADDR_W  rd of issuing instruction
- o_stall  output  1  issue blocked this cycle (combinational)
- o_issue_accept  output  1  i_issue_valid && !o_stall
- i_writeback_reg_wr_en  input  1  writeback write enable
- i_writeback_wb_mux_result  input  XLEN  writeback data
- i_writeback_write_addr  input  ADDR_W  writeback destination
- o_underflow  output  1  sticky: a writeback retired a register with pending count 0

Behaviour:
- Reset: synchronous, active-high, i_rst sampled on rising edge of i_clk.
  - On reset: all registers = 0, all pending counters = 0, o_underflow = 0.
  - Reset has priority over every write or issue in the same cycle.
  - Reset mid-stream discards all in-flight pending state.
  - After reset: o_rs*_data = 0 and o_stall = 0 until new state is written.
- Write:
  - When i_writeback_reg_wr_en = 1 and addr != 0, reg[addr] <= data at the edge.
  - Writes to x0 are dropped.
- Read (combinational):
  - Address 0 -> 0.
  - Else, if a writeback this cycle targets the same address -> i_writeback_wb_mux_result (bypass).
  - Else -> reg[addr].
- Pending counter pend[r], with wb = writeback enabled to r (r != 0) and iss = o_issue_accept && i_issue_wr_en && rd == r (r != 0):
  - iss && !wb -> +1.
  - wb && !iss -> -1, floored at 0.
  - Both -> unchanged.
  - pend[0] is always 0.
- Underflow: wb to r with pend[r] == 0 and no iss to r in the same cycle -> o_underflow <= 1. It stays set until reset. The data write still occurs.
- Effective busy (combinational), computed for rs1 and rs2 independently:
  - busy(r) = pend[r] != 0, except NOT busy when r != 0, a writeback to r occurs this cycle, and pend[r] == 1 (the last pending value is being bypassed).
- o_stall = i_issue_valid && ( (i_rs1_used && busy(rs1)) || (i_rs2_used && busy(rs2)) || (i_issue_wr_en && rd != 0 && pend[rd] == max && no wb to rd this cycle) ).
  - The last term prevents counter overflow.
- Stalled issue: no state change from that issue request. A writeback in the same cycle still applies.
- Latency:
  - Read: 0 cycles (combinational).
  - Write and scoreboard update: visible 1 cycle after the edge.
  - Read-after-write in the same cycle: covered by the bypass.

Test Plan:
- Reset, then read x1 and x31 -> o_rs1_data = 0, o_rs2_data = 0, o_stall = 0, o_underflow = 0.
- Issue rd = 5 (valid, wr_en). Next cycle decode with rs1 = 5, used -> o_stall = 1. Writeback x5 = 0xDEADBEEF the same cycle as a read of rs1 = 5 -> o_rs1_data = 0xDEADBEEF, o_stall = 0. Next cycle pend[5] = 0.
- Writeback to x0 with data 0x12345678 -> read x0 = 0, issue with rd = 0 never stalls, pend[0] stays 0.
- Issue rd = 7 three times, with PEND_W = 2 -> fourth issue to rd = 7 gives o_stall = 1, o_issue_accept = 0. Same cycle, add a writeback to x7 -> that issue is accepted and pend[7] stays 3.
- Issue rd = 9 and writeback rd = 9 in the same cycle with pend[9] = 1 -> pend[9] stays 1 and the read of x9 is still busy next cycle. Writeback to x10 with pend[10] = 0 -> o_underflow = 1, reg[10] updated.
- Issue rd = 3, assert i_rst for 1 cycle -> pend[3] = 0, x3 = 0, o_stall = 0 for a read of rs1 = 3 after reset.

Source files
------------

// File: rtl/register_file_scoreboard.sv
// Integer register file with write-first bypass and a per-register pending-write
// scoreboard that decode uses to stall on RAW hazards and counter saturation.

module register_file_scoreboard_entry #(
    parameter int XLEN   = 32,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb,
    input  logic              iss,
    input  logic [XLEN-1:0]   data,
    output logic [XLEN-1:0]   value,
    output logic [PEND_W-1:0] pend,
    output logic              under
);
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            pend  <= '0;
        end else begin
            if (wb)
                value <= data;
            if (iss && !wb)
                pend <= pend + PEND_W'(1);
            else if (wb && !iss && pend != '0)
                pend <= pend - PEND_W'(1);
        end
    end

    // A retire with nothing outstanding; an issue in the same cycle absorbs it.
    assign under = wb && !iss && (pend == '0);
endmodule

module register_file_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int PEND_W   = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_rs1_addr,
    input  logic [ADDR_W-1:0] i_rs2_addr,
    input  logic              i_rs1_used,
    input  logic              i_rs2_used,
    output logic [XLEN-1:0]   o_rs1_data,
    output logic [XLEN-1:0]   o_rs2_data,
    input  logic              i_issue_valid,
    input  logic              i_issue_wr_en,
    input  logic [ADDR_W-1:0] i_issue_rd_addr,
    output logic              o_stall,
    output logic              o_issue_accept,
    input  logic              i_writeback_reg_wr_en,
    input  logic [XLEN-1:0]   i_writeback_wb_mux_result,
    input  logic [ADDR_W-1:0] i_writeback_write_addr,
    output logic              o_underflow
);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    wb_req_t                            wb_req;
    logic [NUM_REGS-1:0][XLEN-1:0]      regs;
    logic [NUM_REGS-1:0][PEND_W-1:0]    pend;
    logic [NUM_REGS-1:0]                under;
    logic [1:0][ADDR_W-1:0]             rs_addr;
    logic [1:0][XLEN-1:0]               rs_data;
    logic [1:0]                         busy;
    logic                               rd_full;
    logic                               accept;

    assign wb_req  = '{en: i_writeback_reg_wr_en,
                       addr: i_writeback_write_addr,
                       data: i_writeback_wb_mux_result};
    assign rs_addr = {i_rs2_addr, i_rs1_addr};

    // x0 carries no state at all.
    assign regs[0]  = '0;
    assign pend[0]  = '0;
    assign under[0] = 1'b0;

    genvar r;
    generate
        for (r = 1; r < NUM_REGS; r++) begin : g_reg
            logic wb_r;
            logic iss_r;
            assign wb_r  = wb_req.en && (wb_req.addr == ADDR_W'(r));
            assign iss_r = accept && i_issue_wr_en && (i_issue_rd_addr == ADDR_W'(r));

            register_file_scoreboard_entry #(
                .XLEN   (XLEN),
                .PEND_W (PEND_W)
            ) u_entry (
                .clk   (i_clk),
                .rst   (i_rst),
                .wb    (wb_r),
                .iss   (iss_r),
                .data  (wb_req.data),
                .value (regs[r]),
                .pend  (pend[r]),
                .under (under[r])
            );
        end
    endgenerate

    // Read ports: x0 -> 0, same-cycle writeback wins, else stored value.
    // A register whose only pending write is retiring now is not busy.
    always_comb begin
        rs_data = '0;
        busy    = '0;
        for (int p = 0; p < 2; p++) begin
            if (rs_addr[p] != '0) begin
                if (wb_req.en && wb_req.addr == rs_addr[p]) begin
                    rs_data[p] = wb_req.data;
                    busy[p]    = (pend[rs_addr[p]] != '0) && (pend[rs_addr[p]] != PEND_ONE);
                end else begin
                    rs_data[p] = regs[rs_addr[p]];
                    busy[p]    = (pend[rs_addr[p]] != '0);
                end
            end
        end
    end

    // Saturated counter with no retire this cycle would overflow on issue.
    always_comb begin
        rd_full = i_issue_wr_en && (i_issue_rd_addr != '0) &&
                  (pend[i_issue_rd_addr] == PEND_MAX) &&
                  !(wb_req.en && wb_req.addr == i_issue_rd_addr);
    end

    assign o_stall        = i_issue_valid && ((i_rs1_used && busy[0]) ||
                                              (i_rs2_used && busy[1]) ||
                                              rd_full);
    assign accept         = i_issue_valid && !o_stall;
    assign o_issue_accept = accept;
    assign o_rs1_data     = rs_data[0];
    assign o_rs2_data     = rs_data[1];

    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_underflow <= 1'b0;
        else if (|under)
            o_underflow <= 1'b1;
    end
endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench for register_file_scoreboard: bypass, scoreboard stall,
// saturation, x0 handling, underflow and reset discard.

module tb_register_file_scoreboard;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [4:0]  i_rs1_addr, i_rs2_addr, i_issue_rd_addr, i_writeback_write_addr;
    logic        i_rs1_used, i_rs2_used, i_issue_valid, i_issue_wr_en;
    logic        i_writeback_reg_wr_en;
    logic [31:0] i_writeback_wb_mux_result;
    logic [31:0] o_rs1_data, o_rs2_data;
    logic        o_stall, o_issue_accept, o_underflow;

    int total = 0;
    int bad   = 0;

    register_file_scoreboard #(.XLEN(32), .NUM_REGS(32), .ADDR_W(5), .PEND_W(2)) dut (
        .i_clk                     (i_clk),
        .i_rst                     (i_rst),
        .i_rs1_addr                (i_rs1_addr),
        .i_rs2_addr                (i_rs2_addr),
        .i_rs1_used                (i_rs1_used),
        .i_rs2_used                (i_rs2_used),
        .o_rs1_data                (o_rs1_data),
        .o_rs2_data                (o_rs2_data),
        .i_issue_valid             (i_issue_valid),
        .i_issue_wr_en             (i_issue_wr_en),
        .i_issue_rd_addr           (i_issue_rd_addr),
        .o_stall                   (o_stall),
        .o_issue_accept            (o_issue_accept),
        .i_writeback_reg_wr_en     (i_writeback_reg_wr_en),
        .i_writeback_wb_mux_result (i_writeback_wb_mux_result),
        .i_writeback_write_addr    (i_writeback_write_addr),
        .o_underflow               (o_underflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_rst = 1'b0;
        i_rs1_addr = '0; i_rs2_addr = '0; i_rs1_used = 1'b0; i_rs2_used = 1'b0;
        i_issue_valid = 1'b0; i_issue_wr_en = 1'b0; i_issue_rd_addr = '0;
        i_writeback_reg_wr_en = 1'b0; i_writeback_wb_mux_result = '0; i_writeback_write_addr = '0;
    endtask

    // Advance one edge, then leave inputs at idle for the next cycle's setup.
    task automatic tick();
        @(posedge i_clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] rd);
        i_issue_valid = 1'b1; i_issue_wr_en = 1'b1; i_issue_rd_addr = rd;
    endtask

    task automatic wback(input logic [4:0] a, input logic [31:0] d);
        i_writeback_reg_wr_en = 1'b1; i_writeback_write_addr = a; i_writeback_wb_mux_result = d;
    endtask

    task automatic read1(input logic [4:0] a);
        i_issue_valid = 1'b1; i_rs1_addr = a; i_rs1_used = 1'b1;
    endtask

    initial begin
        idle();
        i_rst = 1'b1;
        tick();

        // Reset state
        i_rs1_addr = 5'd1; i_rs2_addr = 5'd31; i_rs1_used = 1'b1; i_rs2_used = 1'b1;
        i_issue_valid = 1'b1;
        #1;
        chk("rst_rs1", o_rs1_data, 32'h0);
        chk("rst_rs2", o_rs2_data, 32'h0);
        chk("rst_stall", {31'b0, o_stall}, 32'h0);
        chk("rst_underflow", {31'b0, o_underflow}, 32'h0);
        tick();

        // RAW on x5, then bypassed writeback clears it
        issue(5'd5);
        #1 chk("x5_issue_accept", {31'b0, o_issue_accept}, 32'h1);
        tick();
        read1(5'd5);
        #1 chk("x5_raw_stall", {31'b0, o_stall}, 32'h1);
        chk("x5_raw_accept", {31'b0, o_issue_accept}, 32'h0);
        wback(5'd5, 32'hDEADBEEF);
        #1 chk("x5_bypass_data", o_rs1_data, 32'hDEADBEEF);
        chk("x5_bypass_stall", {31'b0, o_stall}, 32'h0);
        tick();
        read1(5'd5);
        #1 chk("x5_after_stall", {31'b0, o_stall}, 32'h0);
        chk("x5_after_data", o_rs1_data, 32'hDEADBEEF);
        tick();

        // x0: writes dropped, never busy
        wback(5'd0, 32'h12345678);
        read1(5'd0);
        i_issue_wr_en = 1'b1; i_issue_rd_addr = 5'd0;
        #1 chk("x0_read_wb", o_rs1_data, 32'h0);
        chk("x0_issue_stall", {31'b0, o_stall}, 32'h0);
        tick();
        read1(5'd0);
        i_issue_wr_en = 1'b1; i_issue_rd_addr = 5'd0;
        #1 chk("x0_read_after", o_rs1_data, 32'h0);
        chk("x0_pend_zero", {31'b0, o_stall}, 32'h0);
        tick();

        // Saturate x7 at 3 pending
        for (int k = 0; k < 3; k++) begin
            issue(5'd7);
            #1 chk("x7_fill_accept", {31'b0, o_issue_accept}, 32'h1);
            tick();
        end
        issue(5'd7);
        #1 chk("x7_full_stall", {31'b0, o_stall}, 32'h1);
        chk("x7_full_accept", {31'b0, o_issue_accept}, 32'h0);
        wback(5'd7, 32'h70);
        #1 chk("x7_full_wb_accept", {31'b0, o_issue_accept}, 32'h1);
        tick();
        issue(5'd7);
        #1 chk("x7_still_full", {31'b0, o_stall}, 32'h1);
        tick();
        wback(5'd7, 32'h71); tick();
        wback(5'd7, 32'h72); tick();
        read1(5'd7);
        #1 chk("x7_pend1_busy", {31'b0, o_stall}, 32'h1);
        chk("x7_data", o_rs1_data, 32'h72);
        tick();
        wback(5'd7, 32'h73); tick();
        read1(5'd7);
        #1 chk("x7_drained", {31'b0, o_stall}, 32'h0);
        chk("x7_final_data", o_rs1_data, 32'h73);
        chk("x7_no_underflow", {31'b0, o_underflow}, 32'h0);
        tick();

        // Simultaneous issue+writeback on x9 keeps count at 1
        issue(5'd9); tick();
        issue(5'd9); wback(5'd9, 32'h99);
        #1 chk("x9_both_accept", {31'b0, o_issue_accept}, 32'h1);
        tick();
        read1(5'd9);
        #1 chk("x9_still_busy", {31'b0, o_stall}, 32'h1);
        chk("x9_data", o_rs1_data, 32'h99);
        wback(5'd9, 32'h9A);
        #1 chk("x9_last_bypass", {31'b0, o_stall}, 32'h0);
        chk("x9_bypass_data", o_rs1_data, 32'h9A);
        tick();
        chk("x9_no_underflow", {31'b0, o_underflow}, 32'h0);

        // Underflow on x10, data still lands
        wback(5'd10, 32'hA5A5A5A5);
        tick();
        read1(5'd10);
        #1 chk("x10_underflow", {31'b0, o_underflow}, 32'h1);
        chk("x10_data", o_rs1_data, 32'hA5A5A5A5);
        tick();
        tick();
        chk("underflow_sticky", {31'b0, o_underflow}, 32'h1);

        // Reset discards pending and data; reset beats a concurrent write
        wback(5'd3, 32'h33); tick();
        issue(5'd3); tick();
        read1(5'd3);
        #1 chk("x3_pre_rst_busy", {31'b0, o_stall}, 32'h1);
        chk("x3_pre_rst_data", o_rs1_data, 32'h33);
        i_rst = 1'b1;
        wback(5'd4, 32'h44);
        tick();
        read1(5'd3);
        i_rs2_addr = 5'd4; i_rs2_used = 1'b1;
        #1 chk("x3_post_rst_stall", {31'b0, o_stall}, 32'h0);
        chk("x3_post_rst_data", o_rs1_data, 32'h0);
        chk("x4_rst_priority", o_rs2_data, 32'h0);
        chk("post_rst_underflow", {31'b0, o_underflow}, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
